// File: rtl/cmos_crop_window.sv
// Crops a fixed X/Y window out of the 16-bit pixel stream after skipping the first frames following reset.
// Optional sticky geometry error flag enabled with `define CROP_ERR_CHK_EN; 1-cycle latency, never stalls.
module cmos_crop_window #(
  parameter int X_START     = 80,
  parameter int Y_START     = 104,
  parameter int OUT_H       = 480,
  parameter int OUT_V       = 272,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [15:0] data_i,
  output logic        vs_n_o,
  output logic        de_o,
  output logic [15:0] data_o,
  output logic        frame_done,
  output logic        err_o
);

  localparam logic [12:0] XS     = 13'(X_START);
  localparam logic [12:0] XE     = 13'(X_START + OUT_H);
  localparam logic [12:0] YS     = 13'(Y_START);
  localparam logic [12:0] YE     = 13'(Y_START + OUT_V);
  localparam logic [12:0] X_LAST = XE - 13'd1;
  localparam logic [12:0] Y_LAST = YE - 13'd1;
  localparam logic [7:0]  SKIP_N = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {SKIP, WAIT_VS, ACTIVE, HOLD} state_t;

  state_t      state, state_nxt;
  logic        vs_d;
  logic        line_open;
  logic [11:0] x_cnt, y_cnt;
  logic [7:0]  skip_cnt;

  logic vs_rise, vs_fall, in_x, in_y, keep, last_px, line_end;

  assign vs_rise = vs_i & ~vs_d;
  assign vs_fall = ~vs_i & vs_d;
  assign in_x    = ({1'b0, x_cnt} >= XS) && ({1'b0, x_cnt} < XE);
  assign in_y    = ({1'b0, y_cnt} >= YS) && ({1'b0, y_cnt} < YE);

  // Any vsync edge wins over a coincident pixel, which is then dropped.
  assign keep     = (state == ACTIVE) & ~vs_rise & ~vs_fall & de_i & in_x & in_y;
  assign last_px  = keep & ({1'b0, x_cnt} == X_LAST) & ({1'b0, y_cnt} == Y_LAST);
  assign line_end = (state == ACTIVE) & ~vs_rise & ~vs_fall & line_open & ~de_i;

  always_comb begin
    state_nxt = state;
    case (state)
      SKIP: begin
        if (SKIP_N == 8'd0)
          state_nxt = WAIT_VS;
        else if (vs_fall && (skip_cnt == SKIP_N - 8'd1))
          state_nxt = WAIT_VS;
      end
      WAIT_VS: if (vs_fall) state_nxt = ACTIVE;
      ACTIVE: begin
        if (vs_rise)      state_nxt = WAIT_VS;
        else if (last_px) state_nxt = HOLD;
      end
      HOLD:    if (vs_rise) state_nxt = WAIT_VS;
      default: state_nxt = SKIP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKIP;
      vs_d     <= 1'b0;
      skip_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      vs_d  <= vs_i;
      if (state == SKIP && vs_fall)
        skip_cnt <= skip_cnt + 8'd1;
    end
  end

  // line_open marks that a counted word has been seen, so a dropped word never closes a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= 12'd0;
      y_cnt     <= 12'd0;
      line_open <= 1'b0;
    end else if (state == WAIT_VS && vs_fall) begin
      x_cnt     <= 12'd0;
      y_cnt     <= 12'd0;
      line_open <= 1'b0;
    end else if (state == ACTIVE && !vs_rise && !vs_fall) begin
      if (de_i) begin
        line_open <= 1'b1;
        if (x_cnt != 12'hFFF) x_cnt <= x_cnt + 12'd1;
      end else if (line_end) begin
        line_open <= 1'b0;
        x_cnt     <= 12'd0;
        if (y_cnt != 12'hFFF) y_cnt <= y_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_o       <= 1'b0;
      data_o     <= 16'd0;
      frame_done <= 1'b0;
      vs_n_o     <= 1'b1;
    end else begin
      de_o       <= keep;
      frame_done <= last_px;
      vs_n_o     <= (state == SKIP) ? 1'b1 : ~vs_i;
      if (keep) data_o <= data_i;
    end
  end

`ifdef CROP_ERR_CHK_EN
  logic err_set;
  assign err_set = (line_end & in_y & ({1'b0, x_cnt} < XE)) | ((state == ACTIVE) & vs_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_o <= 1'b0;
    else if (err_set) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_crop_window.sv
// Directed bench for cmos_crop_window on a scaled 10x8 frame with a 4x3 window at (3,2).
module tb_cmos_crop_window;

  localparam int XS = 3, YS = 2, OH = 4, OV = 3, W = 10, H = 8;
`ifdef CROP_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_i = 1'b0;
  logic        de_i = 1'b0;
  logic [15:0] data_i = 16'd0;
  logic        vs_n_o, de_o, frame_done, err_o;
  logic [15:0] data_o;

  always #5 clk = ~clk;

  cmos_crop_window #(
    .X_START(XS), .Y_START(YS), .OUT_H(OH), .OUT_V(OV), .SKIP_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
    .vs_n_o(vs_n_o), .de_o(de_o), .data_o(data_o),
    .frame_done(frame_done), .err_o(err_o)
  );

  int n_asrt = 0;
  int n_fail = 0;

  int          de_cnt = 0;
  int          fd_cnt = 0;
  logic [15:0] last_data = 16'd0;
  logic [15:0] fd_data = 16'd0;
  logic        fd_orphan = 1'b0;

  always @(negedge clk) begin
    if (de_o) begin
      de_cnt++;
      last_data = data_o;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_data = data_o;
      if (!de_o) fd_orphan = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_keep(input int x, input int y);
    return (x >= XS) && (x < XS + OH) && (y >= YS) && (y < YS + OV);
  endfunction

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'((y << 10) | x);
  endfunction

  task automatic vs_pulse(input logic exp_vsn, input logic de_on_fall);
    vs_i = 1'b1; de_i = 1'b0;
    tick(); tick();
    chk("vs_n_o", {31'd0, vs_n_o}, {31'd0, exp_vsn});
    tick();
    vs_i = 1'b0;
    if (de_on_fall) begin de_i = 1'b1; data_i = 16'h0FFF; end
    tick();
    de_i = 1'b0;
    tick(); tick();
  endtask

  task automatic line(input int y, input int n, input logic chk_on);
    for (int x = 0; x < n; x++) begin
      de_i = 1'b1; data_i = pix(x, y);
      tick();
      if (chk_on) begin
        chk("de_o", {31'd0, de_o}, {31'd0, exp_keep(x, y)});
        if (exp_keep(x, y)) chk("data_o", {16'd0, data_o}, {16'd0, pix(x, y)});
      end
    end
    de_i = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic frame(input logic exp_vsn, input logic de_on_fall, input int n_lines, input logic chk_on);
    vs_pulse(exp_vsn, de_on_fall);
    for (int y = 0; y < n_lines; y++) line(y, W, chk_on);
  endtask

  int d0, f0;

  initial begin
    tick(); tick();
    chk("rst de_o", {31'd0, de_o}, 32'd0);
    chk("rst data_o", {16'd0, data_o}, 32'd0);
    chk("rst vs_n_o", {31'd0, vs_n_o}, 32'd1);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst err_o", {31'd0, err_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // two skipped frames
    d0 = de_cnt; frame(1'b1, 1'b0, H, 1'b0);
    chk("skip1 de count", de_cnt - d0, 32'd0);
    d0 = de_cnt; frame(1'b1, 1'b0, H, 1'b0);
    chk("skip2 de count", de_cnt - d0, 32'd0);

    // first kept frame
    d0 = de_cnt; f0 = fd_cnt;
    frame(1'b0, 1'b0, H, 1'b1);
    chk("f3 de count", de_cnt - d0, 32'd12);
    chk("f3 frame_done count", fd_cnt - f0, 32'd1);
    chk("f3 fd data", {16'd0, fd_data}, 32'h1006);
    chk("f3 last data", {16'd0, last_data}, 32'h1006);
    chk("f3 err_o", {31'd0, err_o}, 32'd0);

    // word coincident with vsync fall is dropped
    d0 = de_cnt; f0 = fd_cnt;
    frame(1'b0, 1'b1, H, 1'b1);
    chk("f4 de count", de_cnt - d0, 32'd12);
    chk("f4 frame_done count", fd_cnt - f0, 32'd1);
    chk("f4 err_o", {31'd0, err_o}, 32'd0);

    // frame cut by vsync rising mid-window
    d0 = de_cnt; f0 = fd_cnt;
    frame(1'b0, 1'b0, 3, 1'b1);
    for (int x = 0; x < 4; x++) begin
      de_i = 1'b1; data_i = pix(x, 3);
      tick();
    end
    chk("cut pre de_o", {31'd0, de_o}, 32'd1);
    chk("cut pre data_o", {16'd0, data_o}, 32'h0C03);
    vs_i = 1'b1; de_i = 1'b1; data_i = pix(4, 3);
    tick();
    chk("cut de_o", {31'd0, de_o}, 32'd0);
    de_i = 1'b0;
    tick(); tick();
    chk("cut de count", de_cnt - d0, 32'd5);
    chk("cut frame_done count", fd_cnt - f0, 32'd0);
    chk("cut err_o", {31'd0, err_o}, {31'd0, ERR_EN});

    // asynchronous reset in the middle of a kept line
    frame(1'b0, 1'b0, 4, 1'b1);
    for (int x = 0; x < 5; x++) begin
      de_i = 1'b1; data_i = pix(x, 4);
      tick();
    end
    chk("prerst de_o", {31'd0, de_o}, 32'd1);
    chk("prerst data_o", {16'd0, data_o}, 32'h1004);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst de_o", {31'd0, de_o}, 32'd0);
    chk("mid rst data_o", {16'd0, data_o}, 32'd0);
    chk("mid rst vs_n_o", {31'd0, vs_n_o}, 32'd1);
    chk("mid rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("mid rst err_o", {31'd0, err_o}, 32'd0);
    de_i = 1'b0;
    tick();
    @(negedge clk); rst_n = 1'b1;
    tick();

    d0 = de_cnt; frame(1'b1, 1'b0, H, 1'b0);
    chk("rskip1 de count", de_cnt - d0, 32'd0);
    d0 = de_cnt; frame(1'b1, 1'b0, H, 1'b0);
    chk("rskip2 de count", de_cnt - d0, 32'd0);

    // kept frame with a short line inside the window
    d0 = de_cnt; f0 = fd_cnt;
    vs_pulse(1'b0, 1'b0);
    for (int y = 0; y < 3; y++) line(y, W, 1'b1);
    line(3, 5, 1'b1);
    chk("short err_o", {31'd0, err_o}, {31'd0, ERR_EN});
    for (int y = 4; y < H; y++) line(y, W, 1'b1);
    chk("short de count", de_cnt - d0, 32'd10);
    chk("short frame_done count", fd_cnt - f0, 32'd1);
    chk("short last data", {16'd0, last_data}, 32'h1006);
    chk("frame_done with de_o", {31'd0, fd_orphan}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
